// File: rtl/ddr3_pixel_reader_if.sv
// Frame control, Avalon-MM burst-read and pixel-stream signals of ddr3_pixel_reader.
// master = the reader; slave = the memory/stream environment.
interface ddr3_pixel_reader_if #(
  parameter int out_width = 16
);
  logic                 frame_start;
  logic                 frame_busy;
  logic                 frame_done;
  logic [26:0]          ddr3_read_address;
  logic                 ddr3_read;
  logic [7:0]           ddr3_burstcount;
  logic                 ddr3_waitrequest;
  logic [255:0]         ddr3_readdata;
  logic                 ddr3_readdatavalid;
  logic [out_width-1:0] pixel;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic [7:0]           fifo_level;

  modport master (
    input  frame_start, ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid, pixel_ready,
    output frame_busy, frame_done, ddr3_read_address, ddr3_read, ddr3_burstcount,
           pixel, pixel_valid, fifo_level
  );

  modport slave (
    output frame_start, ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid, pixel_ready,
    input  frame_busy, frame_done, ddr3_read_address, ddr3_read, ddr3_burstcount,
           pixel, pixel_valid, fifo_level
  );
endinterface

// File: rtl/ddr3_pixel_reader.sv
// Burst-reads a packed pixel frame from DDR3 into a word FIFO and unpacks it LSB-first onto a valid/ready stream.
// Define DDR3_READER_LOOP_EN to keep prefetching and streaming frames forever after a single frame_start.
module ddr3_pixel_reader #(
  parameter int          out_width     = 16,
  parameter int          burst_len     = 8,
  parameter int          num_pixels    = 2764800,
  parameter logic [31:0] start_address = 32'h36000000,
  parameter int          fifo_depth    = 64
) (
  input logic                 ddr3_clk,
  input logic                 ddr3_clk_reset,
  ddr3_pixel_reader_if.master bus
);
  localparam int PPW       = 256 / out_width;
  localparam int NUM_READS = num_pixels / PPW / burst_len;
  localparam int PTR_W     = $clog2(fifo_depth);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RD_W      = $clog2(NUM_READS + 1);
  localparam int IDX_W     = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [26:0]      BASE_ADDR = start_address[31:5];
  localparam logic [CNT_W:0]   SPACE_LIM = (CNT_W+1)'(fifo_depth - burst_len);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SPACE, ST_REQ, ST_DRAIN} state_t;

  state_t               state_q;
  logic [26:0]          addr_q;
  logic                 read_q;
  logic                 busy_q;
  logic                 done_q;
  logic [RD_W-1:0]      read_cnt_q;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [255:0]         mem_q [fifo_depth];
  logic [255:0]         head;
  logic [255:0]         shift_q;
  logic [IDX_W-1:0]     idx_q;
  logic [out_width-1:0] pixel_q;
  logic                 pixel_valid_q;
  logic                 accept, push, pop, advance, last_px;
  logic [CNT_W:0]       credit;

  assign accept  = read_q && !bus.ddr3_waitrequest;
  // Data arriving with nothing outstanding is left over from before a reset.
  assign push    = bus.ddr3_readdatavalid && (outstanding_q != '0);
  assign advance = pixel_valid_q && bus.pixel_ready;
  assign last_px = (idx_q == IDX_W'(PPW - 1));
  assign pop     = (count_q != '0) && (!pixel_valid_q || (advance && last_px));
  assign head    = mem_q[rd_ptr_q];
  assign credit  = {1'b0, count_q} + {1'b0, outstanding_q};

  always_comb begin
    outstanding_d = outstanding_q + (accept ? CNT_W'(burst_len) : '0) - (push ? CNT_W'(1) : '0);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge ddr3_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.ddr3_readdata;
  end

  always_ff @(posedge ddr3_clk or posedge ddr3_clk_reset) begin
    if (ddr3_clk_reset) begin
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      shift_q       <= '0;
      idx_q         <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // A pop on the last pixel of a word reloads directly, so words stream without a bubble.
      if (pop) begin
        pixel_q       <= head[out_width-1:0];
        shift_q       <= head >> out_width;
        idx_q         <= '0;
        pixel_valid_q <= 1'b1;
      end else if (advance) begin
        if (last_px) begin
          pixel_valid_q <= 1'b0;
        end else begin
          pixel_q <= shift_q[out_width-1:0];
          shift_q <= shift_q >> out_width;
          idx_q   <= idx_q + IDX_W'(1);
        end
      end
    end
  end

`ifdef DDR3_READER_LOOP_EN
  localparam int PX_W = (num_pixels > 1) ? $clog2(num_pixels) : 1;
  logic [PX_W-1:0] pix_cnt_q;
`endif

  always_ff @(posedge ddr3_clk or posedge ddr3_clk_reset) begin
    if (ddr3_clk_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      read_cnt_q <= '0;
`ifdef DDR3_READER_LOOP_EN
      pix_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) begin
            addr_q     <= BASE_ADDR;
            read_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (credit <= SPACE_LIM) begin
            read_q  <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!bus.ddr3_waitrequest) begin
            read_q     <= 1'b0;
            read_cnt_q <= read_cnt_q + RD_W'(1);
            addr_q     <= addr_q + 27'(burst_len);
            state_q    <= (read_cnt_q == RD_W'(NUM_READS - 1)) ? ST_DRAIN : ST_WAIT_SPACE;
          end
        end
        ST_DRAIN: begin
`ifdef DDR3_READER_LOOP_EN
          addr_q     <= BASE_ADDR;
          read_cnt_q <= '0;
          state_q    <= ST_WAIT_SPACE;
`else
          if (outstanding_q == '0 && count_q == '0 && !pixel_valid_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef DDR3_READER_LOOP_EN
      // Frames overlap in the FIFO here, so frame boundaries are tracked by delivered pixels.
      if (advance) begin
        if (pix_cnt_q == PX_W'(num_pixels - 1)) begin
          pix_cnt_q <= '0;
          done_q    <= 1'b1;
        end else begin
          pix_cnt_q <= pix_cnt_q + PX_W'(1);
        end
      end
`endif
    end
  end

  assign bus.frame_busy        = busy_q;
  assign bus.frame_done        = done_q;
  assign bus.ddr3_read_address = addr_q;
  assign bus.ddr3_read         = read_q;
  assign bus.ddr3_burstcount   = 8'(burst_len);
  assign bus.pixel             = pixel_q;
  assign bus.pixel_valid       = pixel_valid_q;
  assign bus.fifo_level        = (32'(count_q) > 32'd255) ? 8'hFF : 8'(count_q);
endmodule

// File: tb/tb_ddr3_pixel_reader.sv
// Directed bench for ddr3_pixel_reader: memory slave model, pixel sink, and a linear sequence of checks.
module tb_ddr3_pixel_reader;
  localparam logic [26:0] BASE = 27'h1B00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr3_pixel_reader_if #(.out_width(16)) bus();

  ddr3_pixel_reader #(
    .out_width(16), .burst_len(8), .num_pixels(256),
    .start_address(32'h36000000), .fifo_depth(16)
  ) dut (
    .ddr3_clk(clk), .ddr3_clk_reset(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // written by the initial block only
  int ready_mode  = 1;
  bit gap_en      = 1'b0;
  int stale_total = 0;
  int px_base     = 0;

  // written by the slave model only
  logic [26:0] acc_q[$];
  int          wq[$];
  int          stale_sent = 0;
  int          first_rdv  = -1;
  int          w;

  // written by the pixel sink only
  int          got_px    = 0;
  int          px_err    = 0;
  int          stab_err  = 0;
  int          done_cnt  = 0;
  int          busy_err  = 0;
  int          max_lvl   = 0;
  int          first_vld = -1;
  bit          stall     = 1'b0;
  logic [15:0] stall_px;
  logic        r;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] word_of(int idx);
    logic [255:0] d;
    for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'(16*idx + k);
    return d;
  endfunction

  // Memory slave: returns beats in order, earliest the cycle after the accepting edge.
  always @(negedge clk) begin
    if (rst) begin
      wq.delete();
      bus.ddr3_readdatavalid = 1'b0;
      bus.ddr3_readdata      = '0;
    end else begin
      bus.ddr3_readdatavalid = 1'b0;
      if (stale_sent < stale_total) begin
        bus.ddr3_readdatavalid = 1'b1;
        bus.ddr3_readdata      = {8{32'hDEADBEEF}};
        stale_sent++;
      end else if (wq.size() != 0 && (!gap_en || $urandom_range(1) == 1)) begin
        w = wq.pop_front();
        bus.ddr3_readdata      = word_of(w);
        bus.ddr3_readdatavalid = 1'b1;
        if (first_rdv < 0) first_rdv = cyc;
      end
      if (bus.ddr3_read && !bus.ddr3_waitrequest) begin
        acc_q.push_back(bus.ddr3_read_address);
        for (int i = 0; i < 8; i++) wq.push_back(int'(bus.ddr3_read_address - BASE) + i);
      end
    end
  end

  // Pixel sink: picks ready for the coming edge, then scores the handshake that edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      stall           = 1'b0;
      bus.pixel_ready = 1'b0;
    end else begin
      if (stall && (!bus.pixel_valid || bus.pixel !== stall_px)) stab_err++;
      case (ready_mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        default: r = 1'($urandom_range(1));
      endcase
      bus.pixel_ready = r;
      if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
      if (bus.pixel_valid && first_vld < 0) first_vld = cyc;
      if (bus.pixel_valid && r) begin
        if (bus.pixel !== 16'((got_px - px_base) % 256)) px_err++;
        got_px++;
      end
      stall    = bus.pixel_valid && !r;
      stall_px = bus.pixel;
      if (bus.frame_done) begin
        done_cnt++;
`ifndef DDR3_READER_LOOP_EN
        if (bus.frame_busy !== 1'b0) busy_err++;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(int target, int limit);
    for (int i = 0; i < limit && done_cnt < target; i++) tick();
  endtask

  function automatic logic [26:0] acc_at(int i);
    return (acc_q.size() > i) ? acc_q[i] : 27'h7FFFFFF;
  endfunction

  int a0, d0;

  initial begin
    bus.frame_start      = 1'b0;
    bus.ddr3_waitrequest = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_read",       64'(bus.ddr3_read), 0);
    check("rst_address",    64'(bus.ddr3_read_address), 0);
    check("rst_burstcount", 64'(bus.ddr3_burstcount), 8);
    check("rst_busy",       64'(bus.frame_busy), 0);
    check("rst_done",       64'(bus.frame_done), 0);
    check("rst_pix_valid",  64'(bus.pixel_valid), 0);
    check("rst_pixel",      64'(bus.pixel), 0);
    check("rst_fifo_level", 64'(bus.fifo_level), 0);
    rst = 1'b0;
    tick();

`ifdef DDR3_READER_LOOP_EN
    start_frame();
    wait_done(3, 8000);
    check("loop_done_3",     64'(done_cnt >= 3), 1);
    check("loop_acc_count",  64'(acc_q.size() >= 6), 1);
    check("loop_addr0",      64'(acc_at(0)), 64'(BASE));
    check("loop_addr1",      64'(acc_at(1)), 64'(BASE + 27'd8));
    check("loop_addr2",      64'(acc_at(2)), 64'(BASE));
    check("loop_addr4",      64'(acc_at(4)), 64'(BASE));
    check("loop_pixels",     64'(got_px >= 768), 1);
    check("loop_pix_order",  64'(px_err), 0);
    check("loop_busy",       64'(bus.frame_busy), 1);
    check("loop_stable",     64'(stab_err), 0);
    check("loop_fifo_max",   64'(max_lvl <= 16), 1);
    check("loop_burstcount", 64'(bus.ddr3_burstcount), 8);
`else
    // basic frame, no stalls
    px_base = got_px; a0 = acc_q.size(); d0 = done_cnt;
    start_frame();
    check("f1_busy_up",   64'(bus.frame_busy), 1);
    wait_done(d0 + 1, 3000);
    check("f1_done",      64'(done_cnt), 64'(d0 + 1));
    check("f1_pixels",    64'(got_px - px_base), 256);
    check("f1_pix_order", 64'(px_err), 0);
    check("f1_acc_count", 64'(acc_q.size()), 64'(a0 + 2));
    check("f1_addr0",     64'(acc_at(a0)), 64'(BASE));
    check("f1_addr1",     64'(acc_at(a0 + 1)), 64'(BASE + 27'd8));
    check("f1_busy_down", 64'(bus.frame_busy), 0);
    check("f1_busy_with_done", 64'(busy_err), 0);
    check("f1_latency",   64'((first_vld - first_rdv) >= 1 && (first_vld - first_rdv) <= 3), 1);

    // waitrequest held on the first request
    bus.ddr3_waitrequest = 1'b1;
    px_base = got_px; a0 = acc_q.size(); d0 = done_cnt;
    start_frame();
    for (int i = 0; i < 20 && !bus.ddr3_read; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("wr_read_held",  64'(bus.ddr3_read), 1);
      check("wr_addr_held",  64'(bus.ddr3_read_address), 64'(BASE));
      check("wr_no_accept",  64'(acc_q.size()), 64'(a0));
      tick();
    end
    bus.ddr3_waitrequest = 1'b0;
    wait_done(d0 + 1, 3000);
    check("wr_acc_count", 64'(acc_q.size()), 64'(a0 + 2));
    check("wr_addr0",     64'(acc_at(a0)), 64'(BASE));
    check("wr_addr1",     64'(acc_at(a0 + 1)), 64'(BASE + 27'd8));
    check("wr_pixels",    64'(got_px - px_base), 256);
    check("wr_pix_order", 64'(px_err), 0);

    // downstream stalled for 200 cycles
    ready_mode = 0;
    px_base = got_px; a0 = acc_q.size(); d0 = done_cnt;
    start_frame();
    repeat (200) tick();
    check("st_acc_count",  64'(acc_q.size()), 64'(a0 + 2));
    check("st_fifo_level", 64'(bus.fifo_level), 15);
    check("st_pix_valid",  64'(bus.pixel_valid), 1);
    check("st_pixel0",     64'(bus.pixel), 0);
    check("st_no_done",    64'(done_cnt), 64'(d0));
    ready_mode = 1;
    wait_done(d0 + 1, 3000);
    check("st_pixels",     64'(got_px - px_base), 256);
    check("st_pix_order",  64'(px_err), 0);
    check("st_fifo_max",   64'(max_lvl <= 16), 1);

    // random ready and data gaps, plus a frame_start while busy
    ready_mode = 2; gap_en = 1'b1;
    px_base = got_px; a0 = acc_q.size(); d0 = done_cnt;
    start_frame();
    repeat (20) tick();
    start_frame();
    wait_done(d0 + 1, 5000);
    check("rnd_done",      64'(done_cnt), 64'(d0 + 1));
    check("rnd_pixels",    64'(got_px - px_base), 256);
    check("rnd_pix_order", 64'(px_err), 0);
    check("rnd_stable",    64'(stab_err), 0);
    repeat (30) tick();
    check("rnd_start_ignored_acc",  64'(acc_q.size()), 64'(a0 + 2));
    check("rnd_start_ignored_done", 64'(done_cnt), 64'(d0 + 1));
    ready_mode = 1; gap_en = 1'b0;

    // reset mid-frame, stale beats, then a clean frame
    px_base = got_px; a0 = acc_q.size(); d0 = done_cnt;
    start_frame();
    for (int i = 0; i < 50 && acc_q.size() < a0 + 1; i++) tick();
    rst = 1'b1;
    #1;
    check("mr_read_low",   64'(bus.ddr3_read), 0);
    check("mr_busy_low",   64'(bus.frame_busy), 0);
    check("mr_fifo_empty", 64'(bus.fifo_level), 0);
    tick(); tick();
    rst = 1'b0;
    stale_total = stale_total + 4;
    repeat (10) tick();
    check("mr_stale_sent",   64'(stale_sent), 64'(stale_total));
    check("mr_stale_level",  64'(bus.fifo_level), 0);
    check("mr_stale_pvalid", 64'(bus.pixel_valid), 0);
    check("mr_no_pixels",    64'(got_px), 64'(px_base));
    check("mr_no_done",      64'(done_cnt), 64'(d0));
    px_base = got_px; a0 = acc_q.size();
    start_frame();
    wait_done(d0 + 1, 3000);
    check("mr_done",      64'(done_cnt), 64'(d0 + 1));
    check("mr_pixels",    64'(got_px - px_base), 256);
    check("mr_pix_order", 64'(px_err), 0);
    check("mr_addr0",     64'(acc_at(a0)), 64'(BASE));
    check("mr_acc_count", 64'(acc_q.size()), 64'(a0 + 2));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
